// File: rtl/controller_pkg.sv
// Shared definitions between the code sequencer and the training controller:
// opcode encodings, the instruction word layout and the sequencer FSM states.
package controller_pkg;

    localparam logic [3:0] OP_SET_ACT_DENSE     = 4'd1;
    localparam logic [3:0] OP_SET_COST          = 4'd2;
    localparam logic [3:0] OP_LOAD_WEIGHT       = 4'd3;
    localparam logic [3:0] OP_LOAD_INPUT_LABEL  = 4'd4;
    localparam logic [3:0] OP_SET_LEARNING_RATE = 4'd5;
    localparam logic [3:0] OP_UPDATE_WEIGHT     = 4'd6;
    localparam logic [3:0] OP_STALL             = 4'd7;
    localparam logic [3:0] OP_LOAD_Z            = 4'd8;

    localparam int CODE_W = 12;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] param_a;
        logic [3:0] param_b;
    } code_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/code_mem.sv
// Program store: register array with synchronous write and asynchronous read.
// Contents are deliberately not reset so a program survives rst_n.
module code_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WORD_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/code_sequencer.sv
// Instruction sequencer: steps a program counter through the code store,
// presents the current line to the controller and reacts to its feedback.
module code_sequencer
    import controller_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int OP_W    = 4,
    parameter int PA_W    = 4,
    parameter int PB_W    = 4,
    parameter int EPOCH_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 prog_we,
    input  logic [ADDR_W-1:0]    prog_addr,
    input  logic [11:0]          prog_data,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    last_line,
    input  logic [EPOCH_W-1:0]   epochs,
    input  logic                 count_reset,
    input  logic                 code_active,
    input  logic                 code_reset,
    output logic [OP_W-1:0]      op,
    output logic [PA_W-1:0]      param_a,
    output logic [PB_W-1:0]      param_b,
    output logic [PA_W+PB_W-1:0] param_c,
    output logic [31:0]          code_count,
    output logic                 enable,
    output logic                 busy,
    output logic                 done,
    output logic [EPOCH_W-1:0]   epoch,
    output logic [ADDR_W-1:0]    pc
);

    localparam int WORD_W = OP_W + PA_W + PB_W;

    seq_state_t          state;
    logic [ADDR_W-1:0]   last_q;
    logic [EPOCH_W-1:0]  epochs_q;
    logic [WORD_W-1:0]   rd_word;
    logic                run;
    logic                mem_we;
    logic [ADDR_W-1:0]   last_clamped;
    logic [EPOCH_W-1:0]  epochs_eff;
    logic [EPOCH_W:0]    epoch_nx;
    logic [31:0]         count_nx;

    assign run    = (state == ST_RUN);
    assign mem_we = prog_we && !run;

    code_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (WORD_W'(prog_data)),
        .raddr (pc),
        .rdata (rd_word)
    );

    // Only matters for non-power-of-two DEPTH; keeps pc inside the array.
    assign last_clamped = (int'(last_line) >= DEPTH) ? ADDR_W'(DEPTH - 1) : last_line;
    assign epochs_eff   = (epochs == '0) ? EPOCH_W'(1) : epochs;
    assign epoch_nx     = {1'b0, epoch} + (EPOCH_W+1)'(1);
    assign count_nx     = count_reset ? 32'd0
                        : (code_count == 32'hFFFF_FFFF) ? code_count : code_count + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= '0;
            code_count <= '0;
            epoch      <= '0;
            last_q     <= '0;
            epochs_q   <= EPOCH_W'(1);
        end else begin
            case (state)
                ST_RUN: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        pc         <= '0;
                        code_count <= '0;
                    end else begin
                        code_count <= count_nx;
                        if (code_reset) begin
                            pc <= '0;
                        end else if (code_active) begin
                            if (pc != last_q) begin
                                pc <= pc + ADDR_W'(1);
                            end else if (epoch_nx < {1'b0, epochs_q}) begin
                                pc    <= '0;
                                epoch <= epoch_nx[EPOCH_W-1:0];
                            end else begin
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        pc         <= '0;
                        code_count <= '0;
                    end else if (start) begin
                        state      <= ST_RUN;
                        pc         <= '0;
                        code_count <= '0;
                        epoch      <= '0;
                        last_q     <= last_clamped;
                        epochs_q   <= epochs_eff;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Zero fields outside RUN read as the controller's no-op.
    assign op      = run ? rd_word[WORD_W-1 -: OP_W]  : '0;
    assign param_a = run ? rd_word[PA_W+PB_W-1 -: PA_W] : '0;
    assign param_b = run ? rd_word[PB_W-1:0]           : '0;
    assign param_c = {param_a, param_b};
    assign enable  = run;
    assign busy    = run;
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_code_sequencer.sv
// Self-checking bench: a controller model closes the feedback loop and a
// scoreboard of expected per-cycle {op, pc, code_count, epoch} is drained while busy.
module tb_code_sequencer;
    import controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [11:0] prog_data;
    logic        start, abort;
    logic [5:0]  last_line;
    logic [15:0] epochs;
    logic        count_reset, code_active, code_reset;
    logic [3:0]  op, param_a, param_b;
    logic [7:0]  param_c;
    logic [31:0] code_count;
    logic        enable, busy, done;
    logic [15:0] epoch;
    logic [5:0]  pc;

    logic        force_active, force_reset, sb_on;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  pc;
        logic [31:0] cnt;
        logic [15:0] ep;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] mdl_mem [64];

    code_sequencer dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .abort(abort), .last_line(last_line),
        .epochs(epochs), .count_reset(count_reset), .code_active(code_active),
        .code_reset(code_reset), .op(op), .param_a(param_a), .param_b(param_b),
        .param_c(param_c), .code_count(code_count), .enable(enable), .busy(busy),
        .done(done), .epoch(epoch), .pc(pc)
    );

    always #5 clk = ~clk;

    // Controller model: stall holds the line until code_count reaches param_c,
    // every other op is single-cycle.
    always_comb begin
        code_active = force_active | (enable && ((op == OP_STALL) ? (code_count == 32'(param_c)) : 1'b1));
        count_reset = code_active;
        code_reset  = force_reset;
    end

    always @(negedge clk) begin
        if (sb_on && busy) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got op=%0d pc=%0d cnt=%0d epoch=%0d, expected nothing", op, pc, code_count, epoch);
            end else begin
                e = exp_q.pop_front();
                if (op !== e.op || pc !== e.pc || code_count !== e.cnt || epoch !== e.ep) begin
                    errors++;
                    $display("FAIL sb_line got op=%0d pc=%0d cnt=%0d epoch=%0d, expected op=%0d pc=%0d cnt=%0d epoch=%0d",
                             op, pc, code_count, epoch, e.op, e.pc, e.cnt, e.ep);
                end
            end
        end
    end

    task automatic write_line(input int addr, input logic [11:0] data);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 6'(addr); prog_data = data;
        @(posedge clk); #1;
        prog_we = 1'b0;
        mdl_mem[addr] = data;
    endtask

    task automatic load_prog_a();
        code_word_t w;
        w = '{op: OP_SET_COST,      param_a: 4'd0, param_b: 4'd0}; write_line(0, w);
        w = '{op: OP_STALL,         param_a: 4'd0, param_b: 4'd4}; write_line(1, w);
        w = '{op: OP_SET_ACT_DENSE, param_a: 4'd0, param_b: 4'd0}; write_line(2, w);
    endtask

    task automatic gen_expect(input int last, input int ep);
        int n;
        n = (ep == 0) ? 1 : ep;
        for (int e = 0; e < n; e++)
            for (int l = 0; l <= last; l++) begin
                logic [3:0] o;
                int s;
                o = mdl_mem[l][11:8];
                s = (o == OP_STALL) ? int'(mdl_mem[l][7:0]) : 0;
                for (int c = 0; c <= s; c++)
                    exp_q.push_back('{op: o, pc: 6'(l), cnt: 32'(c), ep: 16'(e)});
            end
    endtask

    task automatic do_start(input int last, input int ep);
        @(negedge clk);
        start = 1'b1; last_line = 6'(last); epochs = 16'(ep);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (busy !== 1'b0 || enable !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b en=%b done=%b, expected 0 0 0", busy, enable, done); end
        checks++; if (op !== 4'd0 || param_c !== 8'd0) begin errors++; $display("FAIL reset_op got op=%0d pc_c=%0d, expected 0 0", op, param_c); end
        checks++; if (pc !== 6'd0 || code_count !== 32'd0 || epoch !== 16'd0) begin errors++; $display("FAIL reset_cnt got pc=%0d cnt=%0d epoch=%0d, expected 0", pc, code_count, epoch); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_program();
        bit ok;
        load_prog_a();
        exp_q.delete(); gen_expect(2, 1); sb_on = 1'b1;
        do_start(2, 1);
        wait_done(60, ok);
        sb_on = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL prog_done timeout, expected done=1"); end
        checks++; if (pc !== 6'd2) begin errors++; $display("FAIL prog_pc got %0d expected 2", pc); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL prog_left got %0d lines unseen expected 0", exp_q.size()); end
        checks++; if (op !== 4'd0 || enable !== 1'b0) begin errors++; $display("FAIL prog_idle_op got op=%0d en=%b expected 0 0", op, enable); end
    endtask

    task automatic test_epochs();
        int cyc;
        write_line(0, 12'h500);
        write_line(1, 12'h600);
        exp_q.delete(); gen_expect(1, 3); sb_on = 1'b1;
        do_start(1, 3);
        cyc = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busy) cyc++;
        end
        sb_on = 1'b0;
        checks++; if (cyc != 6 || done !== 1'b1) begin errors++; $display("FAIL epoch_cycles got %0d done=%b expected 6 1", cyc, done); end
        checks++; if (epoch !== 16'd2 || pc !== 6'd1) begin errors++; $display("FAIL epoch_final got epoch=%0d pc=%0d expected 2 1", epoch, pc); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL epoch_left got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_code_reset();
        bit hit;
        write_line(0, 12'h500);
        write_line(1, 12'h703);
        write_line(2, 12'h100);
        sb_on = 1'b0;
        do_start(2, 1);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (busy && pc == 6'd1) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL creset_reach timeout, expected pc=1"); end
        force_active = 1'b1; force_reset = 1'b1;
        @(posedge clk); #1;
        force_active = 1'b0; force_reset = 1'b0;
        @(negedge clk);
        checks++; if (pc !== 6'd0 || epoch !== 16'd0 || busy !== 1'b1) begin errors++; $display("FAIL creset_pc got pc=%0d epoch=%0d busy=%b expected 0 0 1", pc, epoch, busy); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic test_write_in_run();
        bit ok;
        load_prog_a();
        exp_q.delete(); gen_expect(2, 1); sb_on = 1'b1;
        do_start(2, 1);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 6'd0; prog_data = 12'h7FF;
        @(posedge clk); #1;
        prog_we = 1'b0;
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrun_done1 timeout, expected done=1"); end
        gen_expect(2, 1);
        do_start(2, 1);
        wait_done(60, ok);
        sb_on = 1'b0;
        checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("FAIL wrun_rerun got done=%b left=%0d expected 1 0", ok, exp_q.size()); end
    endtask

    task automatic test_async_reset();
        bit hit, ok;
        sb_on = 1'b0;
        do_start(2, 1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (busy && pc == 6'd1 && code_count == 32'd2) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL arst_reach timeout, expected pc=1 cnt=2"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (op !== 4'd0 || code_count !== 32'd0 || enable !== 1'b0 || pc !== 6'd0) begin errors++; $display("FAIL arst_now got op=%0d cnt=%0d en=%b pc=%0d expected 0 0 0 0", op, code_count, enable, pc); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); gen_expect(2, 1); sb_on = 1'b1;
        do_start(2, 1);
        wait_done(60, ok);
        sb_on = 1'b0;
        checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("FAIL arst_rerun got done=%b left=%0d expected 1 0", ok, exp_q.size()); end
    endtask

    task automatic test_abort();
        bit ok;
        sb_on = 1'b0;
        do_start(2, 1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || op !== 4'd0 || code_count !== 32'd0 || pc !== 6'd0) begin errors++; $display("FAIL abort_idle got busy=%b done=%b op=%0d cnt=%0d pc=%0d expected 0", busy, done, op, code_count, pc); end
        exp_q.delete(); gen_expect(2, 1); sb_on = 1'b1;
        do_start(2, 1);
        wait_done(60, ok);
        sb_on = 1'b0;
        checks++; if (!ok || exp_q.size() != 0) begin errors++; $display("FAIL abort_rerun got done=%b left=%0d expected 1 0", ok, exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        write_line(0, 12'h500);
        exp_q.delete(); gen_expect(0, 0); sb_on = 1'b1;
        do_start(0, 0);
        wait_done(10, ok);
        checks++; if (!ok || exp_q.size() != 0 || pc !== 6'd0 || epoch !== 16'd0) begin errors++; $display("FAIL b2b_ep0 got done=%b left=%0d pc=%0d epoch=%0d expected 1 0 0 0", ok, exp_q.size(), pc, epoch); end
        gen_expect(0, 2);
        do_start(0, 2);
        wait_done(10, ok);
        sb_on = 1'b0;
        checks++; if (!ok || exp_q.size() != 0 || epoch !== 16'd1) begin errors++; $display("FAIL b2b_ep2 got done=%b left=%0d epoch=%0d expected 1 0 1", ok, exp_q.size(), epoch); end
    endtask

    initial begin
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; abort = 1'b0; last_line = '0; epochs = '0;
        force_active = 1'b0; force_reset = 1'b0; sb_on = 1'b0;
        test_reset();
        test_program();
        test_epochs();
        test_code_reset();
        test_write_in_run();
        test_async_reset();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired, expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
